// File: rtl/bus_share_arbiter.sv
// Round-robin owner of a shared WIDTH-bit bus: four requesters, one-hot grant,
// bursts of up to MAX_BURST accepted beats under a valid/ready handshake.
module bus_share_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic             bus_ready,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid,
    output logic [3:0]       ack
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state_r, state_nxt;
    logic [3:0] grant_r, grant_nxt;
    logic [1:0] select_r, select_nxt;
    logic [1:0] last_winner_r, last_winner_nxt;
    logic [3:0] beat_cnt_r, beat_cnt_nxt;

    logic [1:0] pick_base_s;
    logic [1:0] pick_s;
    logic       valid_s;
    logic       beat_s;
    logic       release_s;

    // Search base+1 .. base+4 (mod 4); the base itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Handshake qualifiers and release condition for the current owner.
    always_comb begin
        valid_s     = (grant_r != 4'b0000) && req[select_r];
        beat_s      = valid_s && bus_ready;
        release_s   = (state_r == GRANT) &&
                      (!req[select_r] || (beat_s && (beat_cnt_r == LAST_BEAT)));
        pick_base_s = (state_r == GRANT) ? select_r : last_winner_r;
        pick_s      = rr_pick(req, pick_base_s);
    end

    // Next-state logic; re-arbitration happens in the same edge as release.
    always_comb begin
        state_nxt       = state_r;
        grant_nxt       = grant_r;
        select_nxt      = select_r;
        last_winner_nxt = last_winner_r;
        beat_cnt_nxt    = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt    = GRANT;
                    select_nxt   = pick_s;
                    grant_nxt    = 4'b0001 << pick_s;
                    beat_cnt_nxt = 4'd0;
                end else begin
                    grant_nxt = 4'b0000;
                end
            end
            GRANT: begin
                if (release_s) begin
                    last_winner_nxt = select_r;
                    beat_cnt_nxt    = 4'd0;
                    if (req != 4'b0000) begin
                        select_nxt = pick_s;
                        grant_nxt  = 4'b0001 << pick_s;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 4'b0000;
                    end
                end else if (beat_s) begin
                    beat_cnt_nxt = beat_cnt_r + 4'd1;
                end else begin
                    beat_cnt_nxt = beat_cnt_r;
                end
            end
            default: begin
                state_nxt    = IDLE;
                grant_nxt    = 4'b0000;
                beat_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r       <= IDLE;
            grant_r       <= 4'b0000;
            select_r      <= 2'b00;
            last_winner_r <= 2'd3;
            beat_cnt_r    <= 4'd0;
        end else begin
            state_r       <= state_nxt;
            grant_r       <= grant_nxt;
            select_r      <= select_nxt;
            last_winner_r <= last_winner_nxt;
            beat_cnt_r    <= beat_cnt_nxt;
        end
    end

    // Datapath mux and one-hot beat acknowledge.
    always_comb begin
        case (select_r)
            2'd0:    bus_data = data0;
            2'd1:    bus_data = data1;
            2'd2:    bus_data = data2;
            2'd3:    bus_data = data3;
            default: bus_data = data0;
        endcase
        ack = 4'b0000;
        if (beat_s) begin
            ack[select_r] = 1'b1;
        end else begin
            ack = 4'b0000;
        end
    end

    assign grant     = grant_r;
    assign select    = select_r;
    assign bus_valid = valid_s;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Directed-vector bench for bus_share_arbiter: inputs change 1 time unit after
// each rising edge, outputs are compared one unit later.
module tb_bus_share_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  req;
    logic [15:0] data0, data1, data2, data3;
    logic        bus_ready;
    logic [3:0]  grant;
    logic [1:0]  select;
    logic [15:0] bus_data;
    logic        bus_valid;
    logic [3:0]  ack;

    int vectors;
    int miscompares;

    bus_share_arbiter #(.WIDTH(16), .MAX_BURST(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .bus_ready (bus_ready),
        .grant     (grant),
        .select    (select),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .ack       (ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        req     = 4'b0000;
        cyc();
        Reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset_n     = 1'b0;
        req         = 4'b0000;
        bus_ready   = 1'b1;
        data0       = 16'h0000;
        data1       = 16'h0000;
        data2       = 16'h0000;
        data3       = 16'h0000;
        cyc();
        do_reset();

        // Reset state
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_valid", 32'(bus_valid), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);

        // Sole requester 0 streams with no bubble across burst boundaries
        req   = 4'b0001;
        data0 = 16'hA5A5;
        #1;
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_valid", 32'(bus_valid), 32'h0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t1_grant", 32'(grant), 32'h1);
            chk("t1_valid", 32'(bus_valid), 32'h1);
            chk("t1_ack", 32'(ack), 32'h1);
            chk("t1_data", 32'(bus_data), 32'hA5A5);
            cyc();
        end

        // All four requesting: 4-beat rotation 0,1,2,3,0
        do_reset();
        data0 = 16'h1111;
        data1 = 16'h2222;
        data2 = 16'h3333;
        data3 = 16'h4444;
        req   = 4'b1111;
        #1;
        chk("t2_idle_grant", 32'(grant), 32'h0);
        cyc();
        for (int i = 0; i < 20; i++) begin
            int k;
            k = (i / 4) % 4;
            #1;
            chk("t2_grant", 32'(grant), 32'(1 << k));
            chk("t2_select", 32'(select), 32'(k));
            chk("t2_ack", 32'(ack), 32'(1 << k));
            chk("t2_data", 32'(bus_data), 32'(16'h1111 * (k + 1)));
            cyc();
        end

        // Backpressure on source 1 after two beats
        do_reset();
        data1 = 16'hBEEF;
        data2 = 16'hCAFE;
        req   = 4'b0110;
        #1;
        chk("t3_idle_grant", 32'(grant), 32'h0);
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_pre_grant", 32'(grant), 32'h2);
            chk("t3_pre_ack", 32'(ack), 32'h2);
            cyc();
        end
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_grant", 32'(grant), 32'h2);
            chk("t3_stall_ack", 32'(ack), 32'h0);
            chk("t3_stall_valid", 32'(bus_valid), 32'h1);
            chk("t3_stall_data", 32'(bus_data), 32'hBEEF);
            cyc();
        end
        bus_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_post_grant", 32'(grant), 32'h2);
            chk("t3_post_ack", 32'(ack), 32'h2);
            cyc();
        end
        #1;
        chk("t3_rot_grant", 32'(grant), 32'h4);
        chk("t3_rot_select", 32'(select), 32'h2);

        // Source 2 drops request after one beat
        req = 4'b0101;
        #1;
        chk("t4_beat_valid", 32'(bus_valid), 32'h1);
        chk("t4_beat_ack", 32'(ack), 32'h4);
        cyc();
        req = 4'b0001;
        #1;
        chk("t4_drop_valid", 32'(bus_valid), 32'h0);
        chk("t4_drop_ack", 32'(ack), 32'h0);
        chk("t4_drop_grant", 32'(grant), 32'h4);
        cyc();
        #1;
        chk("t4_next_grant", 32'(grant), 32'h1);
        chk("t4_next_select", 32'(select), 32'h0);

        // last_winner=1, then 0 and 2 request together: 2 wins first
        do_reset();
        req = 4'b0010;
        cyc();
        #1;
        chk("t5_g1_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        #1;
        chk("t5_drop_valid", 32'(bus_valid), 32'h0);
        cyc();
        #1;
        chk("t5_idle_grant", 32'(grant), 32'h0);
        chk("t5_idle_select", 32'(select), 32'h1);
        chk("t5_idle_data", 32'(bus_data), 32'hBEEF);
        req = 4'b0101;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t5_g2_grant", 32'(grant), 32'h4);
            chk("t5_g2_ack", 32'(ack), 32'h4);
            cyc();
        end
        #1;
        chk("t5_g0_grant", 32'(grant), 32'h1);

        // Reset mid-burst of source 3
        do_reset();
        req = 4'b1000;
        #1;
        chk("t6_idle_grant", 32'(grant), 32'h0);
        cyc();
        req = 4'b1001;
        #1;
        chk("t6_g3_grant", 32'(grant), 32'h8);
        chk("t6_g3_ack", 32'(ack), 32'h8);
        cyc();
        #1;
        chk("t6_g3b_grant", 32'(grant), 32'h8);
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(grant), 32'h0);
        chk("t6_rst_valid", 32'(bus_valid), 32'h0);
        chk("t6_rst_select", 32'(select), 32'h0);
        chk("t6_rst_ack", 32'(ack), 32'h0);
        cyc();
        #1;
        chk("t6_after_grant", 32'(grant), 32'h1);
        chk("t6_after_select", 32'(select), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
